// File: rtl/ahb_arbiter_if.sv
// Bundles the signals between the AHB-Lite masters, the arbiter and the downstream bus matrix.
// Ports (all flat, master i at slice i):
//   m_haddr_in, m_hwdata_in, m_htrans_in, m_hsize_in, m_hburst_in, m_hprot_in,
//   m_hwrite_in, m_hmastlock_in                      : master address/control/write data
//   m_hrdata_out, m_hready_out, m_hresp_out,
//   m_hgrant_out                                     : per-master read data, ready, response, grant
//   b_haddr_out .. b_hmastlock_out, b_hwdata_out     : selected master towards the bus matrix
//   b_hrdata_in, b_hready_in, b_hresp_in             : response from the bus matrix
// Modport slave is the arbiter view; modport master is the view of the masters plus bus matrix.
interface ahb_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32
);
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr_in;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata_in;
  logic [NUM_MASTERS*2-1:0]          m_htrans_in;
  logic [NUM_MASTERS*3-1:0]          m_hsize_in;
  logic [NUM_MASTERS*3-1:0]          m_hburst_in;
  logic [NUM_MASTERS*4-1:0]          m_hprot_in;
  logic [NUM_MASTERS-1:0]            m_hwrite_in;
  logic [NUM_MASTERS-1:0]            m_hmastlock_in;

  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hrdata_out;
  logic [NUM_MASTERS-1:0]            m_hready_out;
  logic [NUM_MASTERS-1:0]            m_hresp_out;
  logic [NUM_MASTERS-1:0]            m_hgrant_out;

  logic [ADDR_WIDTH-1:0]             b_haddr_out;
  logic [DATA_WIDTH-1:0]             b_hwdata_out;
  logic [1:0]                        b_htrans_out;
  logic [2:0]                        b_hsize_out;
  logic [2:0]                        b_hburst_out;
  logic [3:0]                        b_hprot_out;
  logic                              b_hwrite_out;
  logic                              b_hmastlock_out;

  logic [DATA_WIDTH-1:0]             b_hrdata_in;
  logic                              b_hready_in;
  logic                              b_hresp_in;

  modport slave (
    input  m_haddr_in, m_hwdata_in, m_htrans_in, m_hsize_in, m_hburst_in, m_hprot_in,
           m_hwrite_in, m_hmastlock_in, b_hrdata_in, b_hready_in, b_hresp_in,
    output m_hrdata_out, m_hready_out, m_hresp_out, m_hgrant_out,
           b_haddr_out, b_hwdata_out, b_htrans_out, b_hsize_out, b_hburst_out, b_hprot_out,
           b_hwrite_out, b_hmastlock_out
  );

  modport master (
    output m_haddr_in, m_hwdata_in, m_htrans_in, m_hsize_in, m_hburst_in, m_hprot_in,
           m_hwrite_in, m_hmastlock_in, b_hrdata_in, b_hready_in, b_hresp_in,
    input  m_hrdata_out, m_hready_out, m_hresp_out, m_hgrant_out,
           b_haddr_out, b_hwdata_out, b_htrans_out, b_hsize_out, b_hburst_out, b_hprot_out,
           b_hwrite_out, b_hmastlock_out
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite bus between NUM_MASTERS masters.
// Ports:
//   clk  : bus clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : ahb_arbiter_if.slave -- master side inputs/outputs and bus-matrix side inputs/outputs
// The address-phase owner drives the bus combinationally (one-cycle arbitration latency);
// the data-phase owner receives write-data steering, ready and response.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input logic          clk,
  input logic          rst,
  ahb_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  // Beats still to follow after the NONSEQ of a defined-length burst.
  function automatic logic [CNT_W-1:0] burst_len_m1(input logic [2:0] burst);
    case (burst)
      BURST_WRAP4,  BURST_INCR4:  burst_len_m1 = CNT_W'(3);
      BURST_WRAP8,  BURST_INCR8:  burst_len_m1 = CNT_W'(7);
      BURST_WRAP16, BURST_INCR16: burst_len_m1 = CNT_W'(15);
      default:                    burst_len_m1 = '0;
    endcase
  endfunction

  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       data_owner_q, data_owner_d;
  logic                   data_valid_q, data_valid_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic [NUM_MASTERS-1:0] req_c;
  logic [ADDR_WIDTH-1:0]  own_addr_c;
  logic [1:0]             own_trans_c;
  logic [2:0]             own_size_c;
  logic [2:0]             own_burst_c;
  logic [3:0]             own_prot_c;
  logic                   own_write_c;
  logic                   own_lock_c;
  logic [DATA_WIDTH-1:0]  dat_wdata_c;
  logic [CNT_W-1:0]       beats_left_c;
  logic                   hold_c;
  logic [IDX_W-1:0]       next_owner_c;
  int unsigned            dist_c;
  int unsigned            best_dist_c;

  // A master requests whenever it presents NONSEQ or SEQ.
  always_comb begin
    req_c = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      req_c[i] = bus.m_htrans_in[i*2+1];
    end
  end

  // Select the address-phase owner's controls and the data-phase owner's write data.
  always_comb begin
    own_addr_c  = '0;
    own_trans_c = TRANS_IDLE;
    own_size_c  = '0;
    own_burst_c = '0;
    own_prot_c  = '0;
    own_write_c = 1'b0;
    own_lock_c  = 1'b0;
    dat_wdata_c = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_addr_c  = bus.m_haddr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_trans_c = bus.m_htrans_in[i*2 +: 2];
        own_size_c  = bus.m_hsize_in[i*3 +: 3];
        own_burst_c = bus.m_hburst_in[i*3 +: 3];
        own_prot_c  = bus.m_hprot_in[i*4 +: 4];
        own_write_c = bus.m_hwrite_in[i];
        own_lock_c  = bus.m_hmastlock_in[i];
      end
      if (data_owner_q == IDX_W'(i)) begin
        dat_wdata_c = bus.m_hwdata_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Beats remaining once the owner's current beat is accepted. An IDLE from the owner
  // abandons any burst (e.g. after ERROR) so a stale count cannot pin the bus forever.
  always_comb begin
    if (own_trans_c == TRANS_NONSEQ) begin
      beats_left_c = burst_len_m1(own_burst_c);
    end else if (own_trans_c == TRANS_SEQ && beat_cnt_q != '0) begin
      beats_left_c = beat_cnt_q - CNT_W'(1);
    end else if (own_trans_c == TRANS_IDLE) begin
      beats_left_c = '0;
    end else begin
      beats_left_c = beat_cnt_q;
    end
  end

  // Keep the owner through locked sequences, defined-length bursts and active INCR bursts.
  assign hold_c = own_lock_c
                | (beats_left_c != '0)
                | (own_burst_c == BURST_INCR && own_trans_c != TRANS_IDLE);

  // Round-robin: nearest requester after the owner, the owner itself last; park if none.
  always_comb begin
    next_owner_c = owner_q;
    best_dist_c  = NUM_MASTERS + 1;
    dist_c       = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      dist_c = (i + NUM_MASTERS - 32'(owner_q)) % NUM_MASTERS;
      if (dist_c == 0) begin
        dist_c = NUM_MASTERS;
      end
      if (req_c[i] && dist_c < best_dist_c) begin
        best_dist_c  = dist_c;
        next_owner_c = IDX_W'(i);
      end
    end
  end

  // Next state: everything frozen while the bus is stalled.
  always_comb begin
    owner_d      = owner_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;
    beat_cnt_d   = beat_cnt_q;
    if (bus.b_hready_in) begin
      data_valid_d = own_trans_c[1];
      data_owner_d = owner_q;
      beat_cnt_d   = beats_left_c;
      if (!hold_c) begin
        owner_d = next_owner_c;
      end
    end
    grant_d = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      grant_d[i] = (owner_d == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= '0;
      data_owner_q <= '0;
      data_valid_q <= 1'b0;
      beat_cnt_q   <= '0;
      grant_q      <= NUM_MASTERS'(1);
    end else begin
      owner_q      <= owner_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_q      <= grant_d;
    end
  end

  // Bus-matrix side: owner's address phase, data owner's write data; IDLE while in reset.
  assign bus.b_haddr_out     = own_addr_c;
  assign bus.b_htrans_out    = rst ? TRANS_IDLE : own_trans_c;
  assign bus.b_hsize_out     = own_size_c;
  assign bus.b_hburst_out    = own_burst_c;
  assign bus.b_hprot_out     = own_prot_c;
  assign bus.b_hwrite_out    = own_write_c;
  assign bus.b_hmastlock_out = own_lock_c;
  assign bus.b_hwdata_out    = dat_wdata_c;

  assign bus.m_hgrant_out    = grant_q;
  assign bus.m_hrdata_out    = {NUM_MASTERS{bus.b_hrdata_in}};

  // Master side ready/response: non-owner requesters are stalled so their address holds.
  always_comb begin
    bus.m_hready_out = '1;
    bus.m_hresp_out  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (rst) begin
        bus.m_hready_out[i] = 1'b1;
      end else if (owner_q == IDX_W'(i) || (data_valid_q && data_owner_q == IDX_W'(i))) begin
        bus.m_hready_out[i] = bus.b_hready_in;
      end else begin
        bus.m_hready_out[i] = ~req_c[i];
      end
      bus.m_hresp_out[i] = ~rst & data_valid_q & (data_owner_q == IDX_W'(i)) & bus.b_hresp_in;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus randomized traffic
// compared against a ring-walk reference model of ownership and data phases.
module tb_ahb_arbiter;

  localparam int unsigned NM = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ahb_arbiter_if #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ahb_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_m(input int i, input logic [1:0] tr_v, input logic [2:0] bu,
                         input logic [31:0] ad_v, input logic lk_v, input logic wr = 1'b0);
    bus.m_htrans_in[i*2 +: 2]  = tr_v;
    bus.m_hburst_in[i*3 +: 3]  = bu;
    bus.m_haddr_in[i*AW +: AW] = ad_v;
    bus.m_hmastlock_in[i]      = lk_v;
    bus.m_hwrite_in[i]         = wr;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NM; i++) begin
      drive_m(i, IDLE, SINGLE, 32'h0, 1'b0);
      bus.m_hwdata_in[i*DW +: DW] = '0;
      bus.m_hsize_in[i*3 +: 3]    = 3'(i);
      bus.m_hprot_in[i*4 +: 4]    = 4'(i + 3);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_m(1, NONSEQ, SINGLE, 32'h1234, 1'b0);
    bus.b_hresp_in = 1'b1;
    tick(); tick(); settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL reset_grant: got %b want 001", bus.m_hgrant_out); end
    n_checks++; if (bus.b_htrans_out !== IDLE) begin n_fail++; $display("FAIL reset_htrans: got %b want 00", bus.b_htrans_out); end
    n_checks++; if (bus.m_hready_out !== 3'b111) begin n_fail++; $display("FAIL reset_hready: got %b want 111", bus.m_hready_out); end
    n_checks++; if (bus.m_hresp_out !== 3'b000) begin n_fail++; $display("FAIL reset_hresp: got %b want 000", bus.m_hresp_out); end
    tick();
    idle_all();
    bus.b_hresp_in = 1'b0;
    rst = 1'b0;
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL release_grant: got %b want 001", bus.m_hgrant_out); end
  endtask

  task automatic test_rr_single();
    tick();
    drive_m(0, NONSEQ, SINGLE, 32'h100, 1'b0, 1'b1);
    drive_m(1, NONSEQ, SINGLE, 32'h200, 1'b0, 1'b1);
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL rr_c0_grant: got %b want 001", bus.m_hgrant_out); end
    n_checks++; if (bus.b_haddr_out !== 32'h100) begin n_fail++; $display("FAIL rr_c0_addr: got %h want 100", bus.b_haddr_out); end
    n_checks++; if (bus.m_hready_out[1] !== 1'b0) begin n_fail++; $display("FAIL rr_c0_m1_stall: got %b want 0", bus.m_hready_out[1]); end
    n_checks++; if (bus.m_hready_out[0] !== 1'b1) begin n_fail++; $display("FAIL rr_c0_m0_ready: got %b want 1", bus.m_hready_out[0]); end
    tick();
    drive_m(0, IDLE, SINGLE, 32'h0, 1'b0);
    bus.m_hwdata_in[0 +: DW] = 32'hD0D0;
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL rr_c1_grant: got %b want 010", bus.m_hgrant_out); end
    n_checks++; if (bus.b_haddr_out !== 32'h200) begin n_fail++; $display("FAIL rr_c1_addr: got %h want 200", bus.b_haddr_out); end
    n_checks++; if (bus.b_hwdata_out !== 32'hD0D0) begin n_fail++; $display("FAIL rr_c1_wdata: got %h want d0d0", bus.b_hwdata_out); end
    n_checks++; if (bus.m_hready_out[1] !== 1'b1) begin n_fail++; $display("FAIL rr_c1_m1_ready: got %b want 1", bus.m_hready_out[1]); end
    tick();
    drive_m(1, IDLE, SINGLE, 32'h0, 1'b0);
    bus.m_hwdata_in[DW +: DW] = 32'hD1D1;
    settle();
    n_checks++; if (bus.b_hwdata_out !== 32'hD1D1) begin n_fail++; $display("FAIL rr_c2_wdata: got %h want d1d1", bus.b_hwdata_out); end
    tick(); settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL rr_park: got %b want 010", bus.m_hgrant_out); end
  endtask

  task automatic test_burst();
    tick();
    drive_m(1, NONSEQ, INCR4, 32'h1000, 1'b0);
    drive_m(0, NONSEQ, SINGLE, 32'h300, 1'b0);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        tick();
        drive_m(1, SEQ, INCR4, 32'h1000 + 32'(4*b), 1'b0);
      end
      settle();
      n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL burst_grant_b%0d: got %b want 010", b, bus.m_hgrant_out); end
      n_checks++; if (bus.b_haddr_out !== 32'h1000 + 32'(4*b)) begin n_fail++; $display("FAIL burst_addr_b%0d: got %h want %h", b, bus.b_haddr_out, 32'h1000 + 32'(4*b)); end
      n_checks++; if (bus.m_hready_out[0] !== 1'b0) begin n_fail++; $display("FAIL burst_m0_stall_b%0d: got %b want 0", b, bus.m_hready_out[0]); end
    end
    tick();
    drive_m(1, IDLE, SINGLE, 32'h0, 1'b0);
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL burst_handover: got %b want 001", bus.m_hgrant_out); end
    n_checks++; if (bus.b_haddr_out !== 32'h300) begin n_fail++; $display("FAIL burst_m0_addr: got %h want 300", bus.b_haddr_out); end
    tick();
    drive_m(0, IDLE, SINGLE, 32'h0, 1'b0);
  endtask

  task automatic test_lock();
    for (int t = 0; t < 3; t++) begin
      tick();
      drive_m(0, NONSEQ, SINGLE, 32'h400 + 32'(4*t), 1'b1);
      drive_m(1, NONSEQ, SINGLE, 32'h500, 1'b0);
      settle();
      n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL lock_grant_t%0d: got %b want 001", t, bus.m_hgrant_out); end
      n_checks++; if (bus.b_hmastlock_out !== 1'b1) begin n_fail++; $display("FAIL lock_out_t%0d: got %b want 1", t, bus.b_hmastlock_out); end
    end
    tick();
    drive_m(0, IDLE, SINGLE, 32'h0, 1'b0);
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL lock_drop_grant: got %b want 001", bus.m_hgrant_out); end
    tick(); settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL lock_after_grant: got %b want 010", bus.m_hgrant_out); end
    n_checks++; if (bus.b_haddr_out !== 32'h500) begin n_fail++; $display("FAIL lock_after_addr: got %h want 500", bus.b_haddr_out); end
    tick();
    drive_m(1, IDLE, SINGLE, 32'h0, 1'b0);
  endtask

  task automatic test_wait_states();
    tick();
    drive_m(1, NONSEQ, SINGLE, 32'h600, 1'b0);
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL wait_start_grant: got %b want 010", bus.m_hgrant_out); end
    for (int w = 0; w < 2; w++) begin
      tick();
      drive_m(1, IDLE, SINGLE, 32'h0, 1'b0);
      drive_m(0, NONSEQ, SINGLE, 32'h700, 1'b0);
      bus.b_hready_in = 1'b0;
      settle();
      n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL wait_grant_w%0d: got %b want 010", w, bus.m_hgrant_out); end
      n_checks++; if (bus.m_hready_out[1:0] !== 2'b00) begin n_fail++; $display("FAIL wait_hready_w%0d: got %b want 00", w, bus.m_hready_out[1:0]); end
    end
    tick();
    bus.b_hready_in = 1'b1;
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL wait_end_grant: got %b want 010", bus.m_hgrant_out); end
    n_checks++; if (bus.m_hready_out[1:0] !== 2'b10) begin n_fail++; $display("FAIL wait_end_hready: got %b want 10", bus.m_hready_out[1:0]); end
    tick(); settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL wait_switch_grant: got %b want 001", bus.m_hgrant_out); end
    n_checks++; if (bus.b_haddr_out !== 32'h700) begin n_fail++; $display("FAIL wait_switch_addr: got %h want 700", bus.b_haddr_out); end
    tick();
    drive_m(0, IDLE, SINGLE, 32'h0, 1'b0);
  endtask

  task automatic test_error();
    tick();
    drive_m(0, NONSEQ, SINGLE, 32'h800, 1'b0, 1'b0);
    settle();
    n_checks++; if (bus.b_hwrite_out !== 1'b0) begin n_fail++; $display("FAIL err_hwrite: got %b want 0", bus.b_hwrite_out); end
    tick();
    drive_m(0, IDLE, SINGLE, 32'h0, 1'b0);
    bus.b_hresp_in  = 1'b1;
    bus.b_hrdata_in = 32'hCAFEF00D;
    settle();
    n_checks++; if (bus.m_hresp_out[1:0] !== 2'b01) begin n_fail++; $display("FAIL err_hresp: got %b want 01", bus.m_hresp_out[1:0]); end
    n_checks++; if (bus.m_hrdata_out[DW +: DW] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_hrdata_m1: got %h want cafef00d", bus.m_hrdata_out[DW +: DW]); end
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL err_grant: got %b want 001", bus.m_hgrant_out); end
    tick();
    bus.b_hresp_in = 1'b0;
  endtask

  task automatic test_incr_hold();
    tick();
    drive_m(0, NONSEQ, INCR, 32'hA00, 1'b0);
    drive_m(1, NONSEQ, SINGLE, 32'hB00, 1'b0);
    tick();
    drive_m(0, SEQ, INCR, 32'hA04, 1'b0);
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL incr_hold_grant: got %b want 001", bus.m_hgrant_out); end
    tick();
    drive_m(0, IDLE, INCR, 32'h0, 1'b0);
    bus.b_hresp_in = 1'b1;
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL incr_err_grant: got %b want 001", bus.m_hgrant_out); end
    n_checks++; if (bus.m_hresp_out !== 3'b001) begin n_fail++; $display("FAIL incr_err_hresp: got %b want 001", bus.m_hresp_out); end
    tick();
    bus.b_hresp_in = 1'b0;
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL incr_release_grant: got %b want 010", bus.m_hgrant_out); end
    n_checks++; if (bus.b_haddr_out !== 32'hB00) begin n_fail++; $display("FAIL incr_release_addr: got %h want b00", bus.b_haddr_out); end
    tick();
    drive_m(1, IDLE, SINGLE, 32'h0, 1'b0);
  endtask

  task automatic test_reset_midburst();
    tick();
    drive_m(1, NONSEQ, WRAP8, 32'h2000, 1'b0);
    drive_m(0, NONSEQ, SINGLE, 32'h900, 1'b0);
    for (int b = 1; b < 3; b++) begin
      tick();
      drive_m(1, SEQ, WRAP8, 32'h2000 + 32'(4*b), 1'b0);
    end
    settle();
    n_checks++; if (bus.m_hgrant_out !== 3'b010) begin n_fail++; $display("FAIL mid_beat3_grant: got %b want 010", bus.m_hgrant_out); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL mid_rst_grant: got %b want 001", bus.m_hgrant_out); end
    n_checks++; if (bus.b_htrans_out !== IDLE) begin n_fail++; $display("FAIL mid_rst_htrans: got %b want 00", bus.b_htrans_out); end
    n_checks++; if (bus.m_hready_out !== 3'b111) begin n_fail++; $display("FAIL mid_rst_hready: got %b want 111", bus.m_hready_out); end
    tick();
    idle_all();
    tick();
    rst = 1'b0;
    bus.b_hresp_in  = 1'b1;
    bus.b_hready_in = 1'b0;
    settle();
    n_checks++; if (bus.m_hresp_out !== 3'b000) begin n_fail++; $display("FAIL mid_post_hresp: got %b want 000", bus.m_hresp_out); end
    n_checks++; if (bus.m_hready_out !== 3'b110) begin n_fail++; $display("FAIL mid_post_hready: got %b want 110", bus.m_hready_out); end
    n_checks++; if (bus.m_hgrant_out !== 3'b001) begin n_fail++; $display("FAIL mid_post_grant: got %b want 001", bus.m_hgrant_out); end
  endtask

  // Reference: owner walks the ring to the next requester when the bus advances and the
  // owner is not locked; the data phase belongs to whoever owned the previous address phase.
  logic [1:0]  tr [NM];
  logic        lk [NM];
  logic [31:0] ad [NM];
  logic [31:0] wd [NM];

  task automatic test_random();
    int          mo, mdo, nxt;
    logic        mdv, bh, rs;
    logic [31:0] rd;
    logic [NM-1:0] exp_rdy, exp_rsp, exp_g;
    mo = 0; mdo = 0; mdv = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int i = 0; i < NM; i++) begin
        tr[i] = ($urandom_range(0, 99) < 50) ? NONSEQ : IDLE;
        lk[i] = ($urandom_range(0, 99) < 10);
        ad[i] = $urandom;
        wd[i] = $urandom;
        drive_m(i, tr[i], SINGLE, ad[i], lk[i]);
        bus.m_hwdata_in[i*DW +: DW] = wd[i];
      end
      bh = ($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 1));
      rd = $urandom;
      bus.b_hready_in = bh;
      bus.b_hresp_in  = rs;
      bus.b_hrdata_in = rd;
      settle();
      exp_g = NM'(1) << mo;
      for (int i = 0; i < NM; i++) begin
        exp_rdy[i] = (i == mo || (mdv && i == mdo)) ? bh : ~tr[i][1];
        exp_rsp[i] = (mdv && i == mdo) ? rs : 1'b0;
      end
      n_checks++; if (bus.m_hgrant_out !== exp_g) begin n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", cyc, bus.m_hgrant_out, exp_g); end
      n_checks++; if (bus.b_haddr_out !== ad[mo]) begin n_fail++; $display("FAIL rand_addr c%0d: got %h want %h", cyc, bus.b_haddr_out, ad[mo]); end
      n_checks++; if (bus.b_htrans_out !== tr[mo]) begin n_fail++; $display("FAIL rand_htrans c%0d: got %b want %b", cyc, bus.b_htrans_out, tr[mo]); end
      n_checks++; if (bus.b_hsize_out !== 3'(mo) || bus.b_hprot_out !== 4'(mo + 3)) begin n_fail++; $display("FAIL rand_ctrl c%0d: got %h/%h want %h/%h", cyc, bus.b_hsize_out, bus.b_hprot_out, 3'(mo), 4'(mo + 3)); end
      n_checks++; if (bus.b_hwdata_out !== wd[mdo]) begin n_fail++; $display("FAIL rand_wdata c%0d: got %h want %h", cyc, bus.b_hwdata_out, wd[mdo]); end
      n_checks++; if (bus.m_hready_out !== exp_rdy) begin n_fail++; $display("FAIL rand_hready c%0d: got %b want %b", cyc, bus.m_hready_out, exp_rdy); end
      n_checks++; if (bus.m_hresp_out !== exp_rsp) begin n_fail++; $display("FAIL rand_hresp c%0d: got %b want %b", cyc, bus.m_hresp_out, exp_rsp); end
      n_checks++; if (bus.m_hrdata_out[2*DW +: DW] !== rd) begin n_fail++; $display("FAIL rand_hrdata c%0d: got %h want %h", cyc, bus.m_hrdata_out[2*DW +: DW], rd); end
      if (bh) begin
        nxt = mo;
        if (!lk[mo]) begin
          for (int k = 1; k <= NM; k++) begin
            if (tr[(mo + k) % NM][1]) begin
              nxt = (mo + k) % NM;
              break;
            end
          end
        end
        mdv = tr[mo][1];
        mdo = mo;
        mo  = nxt;
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    idle_all();
    bus.b_hready_in = 1'b1;
    bus.b_hresp_in  = 1'b0;
    bus.b_hrdata_in = '0;
    test_reset();
    test_rr_single();
    test_burst();
    test_lock();
    test_wait_states();
    test_error();
    test_incr_hold();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
